// File: rtl/axis_burst_gen.sv
// ---------------------------------------------------------------------------
// axis_burst_gen
//
// AXI4-Stream master that produces runs of fixed-length bursts. A run is
// requested with START while the block is idle; each burst is preceded by a
// programmable number of idle cycles. Beat data is either an incrementing
// count (starting at 1) or a Galois LFSR sequence (starting at the seed),
// continuing across every burst of the run.
//
// Ports
//   M_AXIS_ACLK    in   1         clock
//   M_AXIS_ARESET  in   1         synchronous active-high reset
//   START          in   1         run request, sampled only in IDLE
//   CFG_LEN        in   LEN_W     beats per burst (1..C_MAX_LEN)
//   CFG_BURSTS     in   BST_W     bursts per run (1..C_MAX_BURSTS)
//   CFG_MODE       in   1         0 = incrementing data, 1 = LFSR data
//   M_AXIS_TVALID  out  1         beat valid (registered)
//   M_AXIS_TDATA   out  DW        beat data (registered)
//   M_AXIS_TSTRB   out  DW/8      byte strobes, all ones
//   M_AXIS_TLAST   out  1         last beat of burst (registered)
//   M_AXIS_TREADY  in   1         sink ready
//   BUSY           out  1         run in progress
//   DONE           out  1         one-cycle pulse at run end
//   BEAT_CNT       out  32        accepted beats since reset (wrapping)
// ---------------------------------------------------------------------------
module axis_burst_gen #(
  parameter int          C_M_AXIS_TDATA_WIDTH = 32,
  parameter int          C_M_START_COUNT      = 32,
  parameter int          C_MAX_LEN            = 256,
  parameter int          C_MAX_BURSTS         = 16,
  parameter logic [31:0] C_LFSR_TAPS          = 32'h80200003,
  parameter logic [31:0] C_LFSR_SEED          = 32'h00000001,
  localparam int         LEN_W                = $clog2(C_MAX_LEN + 1),
  localparam int         BST_W                = $clog2(C_MAX_BURSTS + 1)
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESET,
  input  logic                                START,
  input  logic [LEN_W-1:0]                    CFG_LEN,
  input  logic [BST_W-1:0]                    CFG_BURSTS,
  input  logic                                CFG_MODE,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,
  output logic                                BUSY,
  output logic                                DONE,
  output logic [31:0]                         BEAT_CNT
);

  localparam int DW     = C_M_AXIS_TDATA_WIDTH;
  localparam int STRB_W = C_M_AXIS_TDATA_WIDTH / 8;
  localparam int WCNT_W = $clog2(C_M_START_COUNT + 1);

  localparam logic [DW-1:0]     TAPS_D    = DW'(C_LFSR_TAPS);
  localparam logic [DW-1:0]     SEED_D    = DW'(C_LFSR_SEED);
  localparam logic [DW-1:0]     ONE_D     = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0]     ZERO_D    = {DW{1'b0}};
  localparam logic [LEN_W-1:0]  ONE_LEN   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  ZERO_LEN  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  MAX_LEN_V = LEN_W'(C_MAX_LEN);
  localparam logic [BST_W-1:0]  ONE_BST   = {{(BST_W-1){1'b0}}, 1'b1};
  localparam logic [BST_W-1:0]  ZERO_BST  = {BST_W{1'b0}};
  localparam logic [BST_W-1:0]  MAX_BST_V = BST_W'(C_MAX_BURSTS);
  localparam logic [WCNT_W-1:0] ZERO_WCNT = {WCNT_W{1'b0}};
  localparam logic [WCNT_W-1:0] ONE_WCNT  = {{(WCNT_W-1){1'b0}}, 1'b1};
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(C_M_START_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } state_t;

  // One Galois LFSR step: shift right, fold the taps back in when bit 0 was set.
  function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] cur);
    logic [DW-1:0] fb;
    fb = cur[0] ? TAPS_D : ZERO_D;
    return (cur >> 1) ^ fb;
  endfunction

  // Data value that follows cur in the selected mode.
  function automatic logic [DW-1:0] data_next(input logic [DW-1:0] cur,
                                              input logic          lfsr_mode);
    logic [DW-1:0] nxt;
    if (lfsr_mode) begin
      nxt = lfsr_next(cur);
    end else begin
      nxt = cur + ONE_D;
    end
    return nxt;
  endfunction

  // State and datapath registers
  state_t             state_r;
  logic [WCNT_W-1:0]  wait_cnt_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   beat_idx_r;   // 1-based index of the beat on the bus
  logic [BST_W-1:0]   bursts_left_r;
  logic               mode_r;
  logic [DW-1:0]      seq_r;        // first data value of the next burst
  logic               tvalid_r;
  logic [DW-1:0]      tdata_r;
  logic               tlast_r;
  logic               busy_r;
  logic               done_r;
  logic [31:0]        beat_cnt_r;

  // Next-value signals
  state_t             state_nxt_s;
  logic [WCNT_W-1:0]  wait_cnt_nxt_s;
  logic [LEN_W-1:0]   len_nxt_s;
  logic [LEN_W-1:0]   beat_idx_nxt_s;
  logic [BST_W-1:0]   bursts_left_nxt_s;
  logic               mode_nxt_s;
  logic [DW-1:0]      seq_nxt_s;
  logic               tvalid_nxt_s;
  logic [DW-1:0]      tdata_nxt_s;
  logic               tlast_nxt_s;
  logic               busy_nxt_s;
  logic               done_nxt_s;
  logic [31:0]        beat_cnt_nxt_s;

  // Decoded conditions
  logic               start_ok_s;
  logic               xfer_s;
  logic               wait_done_s;
  logic               last_burst_s;
  logic [DW-1:0]      adv_data_s;

  // A run is only accepted with a non-zero, in-range length and burst count.
  assign start_ok_s   = START &&
                        (CFG_LEN != ZERO_LEN) && (CFG_LEN <= MAX_LEN_V) &&
                        (CFG_BURSTS != ZERO_BST) && (CFG_BURSTS <= MAX_BST_V);
  assign xfer_s       = tvalid_r & M_AXIS_TREADY;
  assign wait_done_s  = (wait_cnt_r == WAIT_LAST);
  assign last_burst_s = (bursts_left_r == ONE_BST);
  assign adv_data_s   = data_next(tdata_r, mode_r);

  // State register
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (wait_done_s) begin
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      SEND: begin
        if (xfer_s && tlast_r) begin
          if (last_burst_s) begin
            state_nxt_s = FINISH;
          end else begin
            state_nxt_s = WAIT;
          end
        end else begin
          state_nxt_s = SEND;
        end
      end
      FINISH: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output and datapath next values; everything visible is registered below
  always_comb begin
    wait_cnt_nxt_s    = wait_cnt_r;
    len_nxt_s         = len_r;
    beat_idx_nxt_s    = beat_idx_r;
    bursts_left_nxt_s = bursts_left_r;
    mode_nxt_s        = mode_r;
    seq_nxt_s         = seq_r;
    tvalid_nxt_s      = tvalid_r;
    tdata_nxt_s       = tdata_r;
    tlast_nxt_s       = tlast_r;
    busy_nxt_s        = busy_r;
    done_nxt_s        = 1'b0;
    beat_cnt_nxt_s    = beat_cnt_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          len_nxt_s         = CFG_LEN;
          bursts_left_nxt_s = CFG_BURSTS;
          mode_nxt_s        = CFG_MODE;
          wait_cnt_nxt_s    = ZERO_WCNT;
          busy_nxt_s        = 1'b1;
          // Each run restarts its data sequence.
          seq_nxt_s         = CFG_MODE ? SEED_D : ONE_D;
        end else begin
          busy_nxt_s        = 1'b0;
        end
      end
      WAIT: begin
        if (wait_done_s) begin
          // Present the first beat of the burst in the cycle after WAIT ends.
          wait_cnt_nxt_s = ZERO_WCNT;
          tvalid_nxt_s   = 1'b1;
          tdata_nxt_s    = seq_r;
          tlast_nxt_s    = (len_r == ONE_LEN);
          beat_idx_nxt_s = ONE_LEN;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + ONE_WCNT;
        end
      end
      SEND: begin
        if (xfer_s) begin
          beat_cnt_nxt_s = beat_cnt_r + 32'd1;
          if (tlast_r) begin
            // Burst complete: drop the bus and remember where data resumes.
            tvalid_nxt_s      = 1'b0;
            tlast_nxt_s       = 1'b0;
            seq_nxt_s         = adv_data_s;
            bursts_left_nxt_s = bursts_left_r - ONE_BST;
            wait_cnt_nxt_s    = ZERO_WCNT;
            if (last_burst_s) begin
              done_nxt_s = 1'b1;
            end else begin
              done_nxt_s = 1'b0;
            end
          end else begin
            tdata_nxt_s    = adv_data_s;
            beat_idx_nxt_s = beat_idx_r + ONE_LEN;
            tlast_nxt_s    = ((beat_idx_r + ONE_LEN) == len_r);
          end
        end else begin
          // Stalled: every bus register keeps its value.
          tvalid_nxt_s = tvalid_r;
        end
      end
      FINISH: begin
        busy_nxt_s = 1'b0;
      end
      default: begin
        tvalid_nxt_s = 1'b0;
        tlast_nxt_s  = 1'b0;
        busy_nxt_s   = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      wait_cnt_r    <= ZERO_WCNT;
      len_r         <= ZERO_LEN;
      beat_idx_r    <= ZERO_LEN;
      bursts_left_r <= ZERO_BST;
      mode_r        <= 1'b0;
      seq_r         <= ZERO_D;
      tvalid_r      <= 1'b0;
      tdata_r       <= ZERO_D;
      tlast_r       <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      beat_cnt_r    <= 32'd0;
    end else begin
      wait_cnt_r    <= wait_cnt_nxt_s;
      len_r         <= len_nxt_s;
      beat_idx_r    <= beat_idx_nxt_s;
      bursts_left_r <= bursts_left_nxt_s;
      mode_r        <= mode_nxt_s;
      seq_r         <= seq_nxt_s;
      tvalid_r      <= tvalid_nxt_s;
      tdata_r       <= tdata_nxt_s;
      tlast_r       <= tlast_nxt_s;
      busy_r        <= busy_nxt_s;
      done_r        <= done_nxt_s;
      beat_cnt_r    <= beat_cnt_nxt_s;
    end
  end

  assign M_AXIS_TVALID = tvalid_r;
  assign M_AXIS_TDATA  = tdata_r;
  assign M_AXIS_TLAST  = tlast_r;
  assign M_AXIS_TSTRB  = {STRB_W{1'b1}};
  assign BUSY          = busy_r;
  assign DONE          = done_r;
  assign BEAT_CNT      = beat_cnt_r;

endmodule

// File: tb/tb_axis_burst_gen.sv
// Scoreboard bench for axis_burst_gen: stimulus pushes the expected beats of
// each run into a queue, a negedge monitor pops and compares on every transfer.
module tb_axis_burst_gen;

  localparam int DW    = 32;
  localparam int SC    = 4;
  localparam int MAXL  = 256;
  localparam int MAXB  = 16;
  localparam int LEN_W = $clog2(MAXL + 1);
  localparam int BST_W = $clog2(MAXB + 1);
  localparam logic [31:0] TAPS = 32'h80200003;
  localparam logic [31:0] SEED = 32'h00000001;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [BST_W-1:0] bursts = '0;
  logic             mode = 1'b0;
  logic             tready = 1'b0;
  logic             tvalid;
  logic [DW-1:0]    tdata;
  logic [DW/8-1:0]  tstrb;
  logic             tlast;
  logic             busy;
  logic             done;
  logic [31:0]      beat_cnt;

  axis_burst_gen #(
    .C_M_AXIS_TDATA_WIDTH(DW),
    .C_M_START_COUNT(SC),
    .C_MAX_LEN(MAXL),
    .C_MAX_BURSTS(MAXB),
    .C_LFSR_TAPS(TAPS),
    .C_LFSR_SEED(SEED)
  ) dut (
    .M_AXIS_ACLK(clk),
    .M_AXIS_ARESET(rst),
    .START(start),
    .CFG_LEN(len),
    .CFG_BURSTS(bursts),
    .CFG_MODE(mode),
    .M_AXIS_TVALID(tvalid),
    .M_AXIS_TDATA(tdata),
    .M_AXIS_TSTRB(tstrb),
    .M_AXIS_TLAST(tlast),
    .M_AXIS_TREADY(tready),
    .BUSY(busy),
    .DONE(done),
    .BEAT_CNT(beat_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [DW:0] exp_q[$];      // {tlast, tdata}
  int          xfers = 0;
  int          dones = 0;
  logic [31:0] model_beats = 32'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] lfsr(input logic [31:0] c);
    return (c >> 1) ^ (c[0] ? TAPS : 32'd0);
  endfunction

  // Reference: beats of a run straight from the data rules.
  task automatic push_run(input int l, input int b, input bit m);
    logic [31:0] cur;
    cur = m ? SEED : 32'd1;
    for (int bi = 0; bi < b; bi++) begin
      for (int i = 1; i <= l; i++) begin
        exp_q.push_back({(i == l), cur});
        cur = m ? lfsr(cur) : cur + 32'd1;
      end
    end
  endtask

  // Monitor: compares every transfer and checks stability during stalls.
  initial begin
    logic          stalled;
    logic [DW-1:0] held_d;
    logic          held_l;
    logic [DW:0]   e;
    stalled = 1'b0;
    held_d  = '0;
    held_l  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", 64'(tvalid), 64'd1);
          chk("stall_data", 64'(tdata), 64'(held_d));
          chk("stall_last", 64'(tlast), 64'(held_l));
        end
        if (tvalid && tready) begin
          xfers++;
          chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("beat_data", 64'(tdata), 64'(e[DW-1:0]));
            chk("beat_last", 64'(tlast), 64'(e[DW]));
          end
        end
        stalled = tvalid && !tready;
        held_d  = tdata;
        held_l  = tlast;
        if (done) dones++;
      end
    end
  end

  function automatic logic ready_pat(input int rmode, input int cyc);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return (cyc % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run(input int l, input int b, input bit m, input int rmode,
                     input bit prefill, input bit poke);
    int cyc, first_v, done_at, gap, budget, dones0, busy_drop;
    if (!prefill) push_run(l, b, m);
    model_beats = model_beats + 32'(l * b);
    dones0 = dones;
    @(posedge clk); #1;
    start = 1'b1; len = LEN_W'(l); bursts = BST_W'(b); mode = m;
    @(posedge clk); #1;   // START sampled at this edge
    start  = 1'b0;
    len    = LEN_W'($urandom_range(0, 300));
    bursts = BST_W'($urandom_range(0, 20));
    mode   = 1'($urandom_range(0, 1));
    chk("busy_after_start", 64'(busy), 64'd1);
    cyc = 0; first_v = -1; done_at = -1; gap = 0; busy_drop = 0;
    budget = 40 + b * (SC + 2) + l * b * 16;
    while (done_at < 0 && cyc < budget) begin
      tready = ready_pat(rmode, cyc);
      if (poke && cyc == 6) begin
        start = 1'b1; len = LEN_W'(1); bursts = BST_W'(1); mode = ~m;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (!busy) busy_drop++;
      if (tvalid && first_v < 0) first_v = cyc;
      if (first_v >= 0 && !tvalid && !done) gap++;
      if (done) done_at = cyc;
    end
    start = 1'b0;
    chk("done_seen", 64'(done_at >= 0), 64'd1);
    chk("first_valid_latency", 64'(first_v), 64'(SC));
    if (rmode == 0) chk("done_cycle", 64'(done_at), 64'(SC + l * b + SC * (b - 1)));
    chk("gap_cycles", 64'(gap), 64'(SC * (b - 1)));
    chk("busy_during_run", 64'(busy_drop), 64'd0);
    tready = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_after_finish", 64'(busy), 64'd0);
    chk("done_pulses", 64'(dones - dones0), 64'd1);
    chk("beat_cnt", 64'(beat_cnt), 64'(model_beats));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int x0, d0, cyc, seen_b, seen_v;
    int ill_len[4] = '{0, 257, 5, 5};
    int ill_bst[4] = '{1, 1, 0, 17};

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("tstrb_ones", 64'(tstrb), 64'hF);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run(8, 1, 1'b0, 0, 1'b0, 1'b0);   // back-to-back
    run(8, 1, 1'b0, 1, 1'b0, 1'b0);   // backpressure
    run(3, 2, 1'b0, 0, 1'b0, 1'b0);   // multi-burst
    exp_q.push_back({1'b0, 32'h00000001});
    exp_q.push_back({1'b0, 32'h80200003});
    exp_q.push_back({1'b1, 32'hC0300002});
    run(3, 1, 1'b1, 0, 1'b1, 1'b0);   // LFSR constants

    // Illegal starts from IDLE
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      start = 1'b1; len = LEN_W'(ill_len[k]); bursts = BST_W'(ill_bst[k]); mode = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      seen_b = 0; seen_v = 0;
      for (int c = 0; c < SC + 4; c++) begin
        if (busy) seen_b++;
        if (tvalid) seen_v++;
        @(posedge clk); #1;
      end
      chk("illegal_busy", 64'(seen_b), 64'd0);
      chk("illegal_valid", 64'(seen_v), 64'd0);
    end

    // START while busy must not disturb the run
    run(8, 1, 1'b0, 0, 1'b0, 1'b1);

    // Reset mid-run after three beats
    push_run(8, 1, 1'b0);
    x0 = xfers; d0 = dones;
    @(posedge clk); #1;
    start = 1'b1; len = LEN_W'(8); bursts = BST_W'(1); mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; tready = 1'b1;
    cyc = 0;
    while ((xfers - x0) < 3 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("midrun_beats", 64'(xfers - x0), 64'd3);
    chk("beat_cnt_midrun", 64'(beat_cnt), 64'(model_beats + 32'd3));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mr_tvalid", 64'(tvalid), 64'd0);
    chk("mr_tdata", 64'(tdata), 64'd0);
    chk("mr_tlast", 64'(tlast), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_done", 64'(done), 64'd0);
    chk("mr_beat_cnt", 64'(beat_cnt), 64'd0);
    rst = 1'b0; tready = 1'b0;
    exp_q.delete();
    model_beats = 32'd0;
    repeat (SC + 6) @(posedge clk);
    #1;
    chk("mr_no_done", 64'(dones - d0), 64'd0);
    chk("mr_idle_valid", 64'(tvalid), 64'd0);
    run(4, 1, 1'b0, 0, 1'b0, 1'b0);   // data restarts at 1
    run(4, 1, 1'b1, 2, 1'b0, 1'b0);   // LFSR restarts at seed

    // Random runs
    for (int r = 0; r < 10; r++) begin
      run($urandom_range(1, 12), $urandom_range(1, 4), 1'($urandom_range(0, 1)),
          $urandom_range(0, 2), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_burst_gen.md
AXIS_BURST_GEN -- requirements
Module: axis_burst_gen

Interface
REQ-001 The module SHALL have one clock, M_AXIS_ACLK; reset M_AXIS_ARESET SHALL be synchronous and active-high.
REQ-002 Parameters (name, default, meaning) SHALL be:
- C_M_AXIS_TDATA_WIDTH, 32, data width (multiple of 8).
- C_M_START_COUNT, 32, idle cycles before each burst (>=1).
- C_MAX_LEN, 256, maximum beats per burst; LEN_W = $clog2(C_MAX_LEN+1).
- C_MAX_BURSTS, 16, maximum bursts per run; BST_W = $clog2(C_MAX_BURSTS+1).
- C_LFSR_TAPS, 32'h80200003, Galois LFSR feedback mask (low C_M_AXIS_TDATA_WIDTH bits used).
- C_LFSR_SEED, 32'h00000001, LFSR start value (nonzero).
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- M_AXIS_ACLK, in, 1, clock.
- M_AXIS_ARESET, in, 1, sync active-high reset.
- START, in, 1, run request, sampled only in IDLE.
- CFG_LEN, in, LEN_W, beats per burst.
- CFG_BURSTS, in, BST_W, bursts per run.
- CFG_MODE, in, 1, 0 = incrementing data, 1 = LFSR data.
- M_AXIS_TVALID, out, 1, beat valid.
- M_AXIS_TDATA, out, C_M_AXIS_TDATA_WIDTH, beat data.
- M_AXIS_TSTRB, out, C_M_AXIS_TDATA_WIDTH/8, all ones.
- M_AXIS_TLAST, out, 1, last beat of burst.
- M_AXIS_TREADY, in, 1, sink ready.
- BUSY, out, 1, run in progress.
- DONE, out, 1, one-cycle pulse at run end.
- BEAT_CNT, out, 32, accepted beats since reset, wraps at 2^32.

Function
REQ-004 States SHALL be IDLE, WAIT, SEND, FINISH.
REQ-005 In IDLE, START=1 with CFG_LEN in 1..C_MAX_LEN and CFG_BURSTS in 1..C_MAX_BURSTS SHALL latch CFG_LEN, CFG_BURSTS and CFG_MODE, clear the wait counter, set BUSY, and enter WAIT; any other START SHALL be ignored.
REQ-006 START and CFG_* changes while BUSY=1 SHALL have no effect.
REQ-007 WAIT SHALL last exactly C_M_START_COUNT cycles, then enter SEND.
REQ-008 M_AXIS_TVALID, M_AXIS_TDATA and M_AXIS_TLAST SHALL be driven from registers; TVALID SHALL first be 1 in the cycle after the last WAIT cycle.
REQ-009 A beat transfers when TVALID=1 and TREADY=1 at a rising edge.
REQ-010 While TVALID=1 and TREADY=0, TVALID, TDATA and TLAST SHALL hold their values.
REQ-011 With TREADY held at 1, beats SHALL issue back-to-back at one per cycle, with no bubbles inside a burst.
REQ-012 Incrementing mode: TDATA SHALL be 1 on the first beat of a run and increment by 1 per accepted beat across all bursts of that run, modulo 2^width.
REQ-013 LFSR mode: the first beat of a run SHALL carry C_LFSR_SEED; after each accepted beat, next = (cur>>1) XOR (cur[0] ? C_LFSR_TAPS : 0).
REQ-014 TLAST SHALL be 1 only on beat CFG_LEN of each burst; CFG_LEN=1 gives TLAST on every beat.
REQ-015 After the TLAST beat transfers:
- If bursts remain, the block SHALL enter WAIT and drive TVALID=0 from the next cycle.
- Otherwise it SHALL enter FINISH.
REQ-016 FINISH SHALL last one cycle with DONE=1 and BUSY=1, then enter IDLE with BUSY=0.
REQ-017 BEAT_CNT SHALL increment by 1 on every transferred beat.
REQ-018 A new run SHALL be accepted no earlier than the first IDLE cycle after FINISH.

Reset
REQ-019 While M_AXIS_ARESET=1 at a rising edge, the block SHALL enter IDLE, and the following outputs SHALL become 0: TVALID, TLAST, TDATA, BUSY, DONE and BEAT_CNT. Internal data and LFSR state SHALL be reset.
REQ-020 Reset asserted mid-run SHALL abort the run with no DONE pulse; the next run SHALL restart its data at 1 (incrementing mode) or at C_LFSR_SEED (LFSR mode).

Verification
REQ-021 The bench SHALL cover these scenarios, all with C_M_START_COUNT=4:
- Back-to-back burst: LEN=8, BURSTS=1, MODE=0, TREADY=1, START at edge n -> TVALID=1 for cycles n+5..n+12, TDATA 1..8, TLAST only on 8, DONE pulse at n+13, BEAT_CNT=8.
- Backpressure: same run with TREADY toggling 1,0,0,1,... -> exactly 8 transfers carrying 1..8, TDATA/TLAST stable during stalls, no duplicate or lost beats.
- Multi-burst: LEN=3, BURSTS=2 -> TDATA 1,2,3 | 4,5,6, TLAST on 3 and 6, TVALID=0 for 4 cycles between bursts, one DONE pulse.
- LFSR mode: LEN=3, MODE=1 -> TDATA 0x00000001, 0x80200003, 0xC0300002.
- Reset mid-run: assert reset after 3 beats of LEN=8 -> outputs 0 and no DONE; next run's first TDATA=1.
- Illegal start: START with LEN=0, and START while BUSY -> no state change, BUSY and TVALID unaffected.
